// File: rtl/mem_resp_tracker.sv
// MEM-stage handshake controller: waits for in-order cache data_ok, holds load
// data under WB back-pressure and drops responses owed to flushed requests.
module mem_resp_tracker #(
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              next_allowin_i,
    input  logic              now_valid_i,
    input  logic              now_mem_req_i,
    input  logic              excep_flush_i,
    input  logic              req_fire_i,
    input  logic              data_ok_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              now_allowin_o,
    output logic              now_to_next_valid_o,
    output logic [DATA_W-1:0] now_rdata_o,
    output logic              issue_allow_o,
    output logic [CNT_W-1:0]  outstanding_o,
    output logic              cancel_busy_o,
    output logic              proto_err_o
);

    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  cancel;
    logic [CNT_W-1:0]  total_next;
    logic              got_resp;
    logic              proto_err;
    logic [DATA_W-1:0] hold_data;

    logic dok_eff;
    logic resp_route;
    logic live_resp;
    logic stray_resp;
    logic ready_go;
    logic leave;

    // A response with nothing in flight is ignored by the counters.
    assign dok_eff    = data_ok_i & (total != '0);
    assign total_next = total + CNT_W'(req_fire_i) - CNT_W'(dok_eff);

    // Responses owed to cancelled requests drain first; a flush swallows any same-cycle response.
    assign resp_route = dok_eff & (cancel == '0) & ~excep_flush_i;
    assign live_resp  = resp_route & now_valid_i & now_mem_req_i & ~got_resp;
    assign stray_resp = resp_route & ~live_resp;

    assign ready_go = ~now_mem_req_i | got_resp | live_resp;
    assign leave    = now_to_next_valid_o & next_allowin_i;

    assign now_to_next_valid_o = now_valid_i & ready_go & ~excep_flush_i;
    assign now_allowin_o       = ~now_valid_i | (ready_go & next_allowin_i);
    assign now_rdata_o         = got_resp ? hold_data : (live_resp ? rdata_i : '0);
    assign issue_allow_o       = (total < CNT_W'(MAX_OUTSTANDING));
    assign outstanding_o       = total;
    assign cancel_busy_o       = (cancel != '0);
    assign proto_err_o         = proto_err;

    // NOTE: non-blocking assignments so every register samples pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total     <= '0;
            cancel    <= '0;
            got_resp  <= 1'b0;
            hold_data <= '0;
            proto_err <= 1'b0;
        end else begin
            total     <= total_next;
            proto_err <= proto_err | (data_ok_i & (total == '0)) | stray_resp;
            if (excep_flush_i) begin
                // Everything still owed by the cache, including this cycle's new request, is now stale.
                cancel   <= total_next;
                got_resp <= 1'b0;
            end else begin
                if (dok_eff && (cancel != '0))
                    cancel <= cancel - CNT_W'(1);
                if (live_resp && !leave) begin
                    got_resp  <= 1'b1;
                    hold_data <= rdata_i;
                end else if (leave) begin
                    got_resp <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/mem_resp_tracker.md
Name: mem_resp_tracker

Overview:
- MEM-stage handshake controller for the in-order LoongArch pipeline. It replaces the fixed ready_go=1 MEM control with real data_ok waiting.
- Tracks up to MAX_OUTSTANDING cache requests issued from EXE, in order.
- Holds load data when WB back-pressures.
- Discards responses belonging to requests cancelled by an exception flush.

Parameters:
DATA_W, 32, width of cache read data
MAX_OUTSTANDING, 4, maximum in-flight cache requests (must be at least 1)
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the in-flight counters (derived; do not override)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
next_allowin_i  in  1  WB stage allows a new instruction this cycle
now_valid_i  in  1  MEM stage holds a valid instruction
now_mem_req_i  in  1  MEM instruction issued a cache request while in EXE
excep_flush_i  in  1  exception/ertn flush of the whole pipeline this cycle
req_fire_i  in  1  EXE cache request accepted this cycle (req & addr_ok)
data_ok_i  in  1  cache returns one in-order response this cycle
rdata_i  in  DATA_W  cache read data, valid with data_ok_i
now_allowin_o  out  1  MEM stage can accept from EXE
now_to_next_valid_o  out  1  MEM presents a completed instruction to WB
now_rdata_o  out  DATA_W  load data for the current MEM instruction
issue_allow_o  out  1  EXE may issue another cache request
outstanding_o  out  CNT_W  total in-flight requests
cancel_busy_o  out  1  cancelled responses still pending
proto_err_o  out  1  sticky: data_ok_i arrived with zero in-flight requests

Behaviour:
- Reset (asynchronous, rst_n=0): total=0, cancel=0, got_resp=0, hold_data=0, proto_err=0.
- Reset outputs, given now_valid_i=0: now_allowin_o=1, now_to_next_valid_o=0, now_rdata_o=0, issue_allow_o=1, outstanding_o=0, cancel_busy_o=0, proto_err_o=0.
- Reset mid-operation drops all in-flight state; the cache must also be reset.
- Counters:
  - dok_eff = data_ok_i & (total!=0).
  - total_next = total + req_fire_i - dok_eff. Saturating arithmetic is forbidden; EXE must honour issue_allow_o.
  - issue_allow_o = (total < MAX_OUTSTANDING), combinational on the registered total.
  - outstanding_o = total; cancel_busy_o = (cancel != 0).
- Response routing, no flush this cycle:
  - If cancel!=0 and dok_eff: cancel decrements by 1 and the data is discarded. It never reaches now_rdata_o or hold_data.
  - If cancel==0 and dok_eff: the response belongs to the current MEM instruction.
- Capture into the hold register:
  - Live response: dok_eff & cancel==0 & now_valid_i & now_mem_req_i & ~got_resp.
  - If the instruction does not also leave this cycle: hold_data<=rdata_i, got_resp<=1.
  - A live response when now_valid_i=0, now_mem_req_i=0 or got_resp=1 is a protocol error: set proto_err and drop the data.
- proto_err also sets when data_ok_i=1 and total==0.
- Flush cycle (excep_flush_i=1):
  - cancel<=total_next, which includes a request firing in the same cycle and the current MEM request.
  - A same-cycle data_ok_i is consumed as cancelled (counted in total_next, discarded).
  - got_resp<=0.
- Handshake:
  - ready_go = ~now_mem_req_i | got_resp | live response this cycle.
  - now_to_next_valid_o = now_valid_i & ready_go & ~excep_flush_i.
  - now_allowin_o = ~now_valid_i | (ready_go & next_allowin_i).
  - On leave (now_to_next_valid_o & next_allowin_i): got_resp<=0.
- Data select and latency:
  - now_rdata_o = got_resp ? hold_data : (live response ? rdata_i : 0).
  - Latency from data_ok_i to WB handoff is 0 cycles if WB allows in, otherwise held until it does.
- Store requests use the same path (data_ok required); rdata is ignored downstream.
- Precedence: rst_n > excep_flush_i > response routing > leave.

Test Plan:
- Load hit, no stall: req_fire_i at t0, MEM valid with mem_req at t1, data_ok_i=1, rdata_i=0xDEADBEEF, next_allowin_i=1 at t1 -> now_to_next_valid_o=1 and now_rdata_o=0xDEADBEEF at t1; total returns to 0.
- WB back-pressure: as above but next_allowin_i=0 for t1..t3 -> got_resp=1, now_rdata_o holds 0xDEADBEEF, now_allowin_o=0; release at t4 -> handoff at t4, got_resp=0 at t5.
- Flush with 3 in flight: issue 3 requests, excep_flush_i=1 with total=3 -> cancel=3, cancel_busy_o=1. Then a new load issues and MEM waits; 3 data_ok_i are discarded and the 4th delivers 0x12345678 to now_rdata_o.
- Simultaneous edges: flush in the same cycle as req_fire_i=1 and data_ok_i=1 with total=2 -> total=2, cancel=2. Same-cycle req_fire_i and data_ok_i without flush -> total unchanged.
- Capacity: MAX_OUTSTANDING=4, fire 4 requests with no responses -> issue_allow_o=0, outstanding_o=4; one data_ok_i -> issue_allow_o=1.
- Protocol/reset: data_ok_i with total=0 -> proto_err_o=1 sticky, counters unchanged; assert rst_n=0 mid-stall -> all outputs at reset values immediately, without waiting for a clock edge.
